// File: rtl/aes128_enc_iter_if.sv
// Handshake bundle for the iterative AES-128 core.
// key_out exists only when AES_KEY_OUT_EN is defined.
interface aes128_enc_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct_out;
`ifdef AES_KEY_OUT_EN
  logic [127:0] key_out;

  modport master (
    output in_valid, pt_in, key_in, out_ready,
    input  in_ready, out_valid, ct_out, key_out
  );
  modport slave (
    input  in_valid, pt_in, key_in, out_ready,
    output in_ready, out_valid, ct_out, key_out
  );
`else
  modport master (
    output in_valid, pt_in, key_in, out_ready,
    input  in_ready, out_valid, ct_out
  );
  modport slave (
    input  in_valid, pt_in, key_in, out_ready,
    output in_ready, out_valid, ct_out
  );
`endif
endinterface

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock.
// AES_KEY_OUT_EN adds key_out (round-10 key) for decrypt setup.
module aes128_enc_iter #(
  parameter int UNROLL = 1
) (
  input logic             clk,
  input logic             rst_n,
  aes128_enc_iter_if.slave bus
);

  localparam int NCYC = 10 / UNROLL;
  localparam logic [3:0] RLAST = 4'(UNROLL * NCYC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (!(UNROLL == 1 || UNROLL == 2 ||
        UNROLL == 5 || UNROLL == 10)) begin : g_bad
    $error("aes128_enc_iter: UNROLL %0d illegal", UNROLL);
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // inverse as x^254, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, t, inv;
    x2  = gmul(x, x);
    x3  = gmul(x2, x);
    x6  = gmul(x3, x3);
    x12 = gmul(x6, x6);
    x15 = gmul(x12, x3);
    t   = x15;
    for (int i = 0; i < 4; i++) t = gmul(t, t);
    inv = gmul(gmul(t, x12), x2);
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_f(
    input logic [127:0] s,
    input logic [127:0] rk,
    input logic         last
  );
    logic [127:0] sb, sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++)
      sb[8*i +: 8] = sbox(s[8*i +: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[8*(4*c)   +: 8];
      a1 = sr[8*(4*c+1) +: 8];
      a2 = sr[8*(4*c+2) +: 8];
      a3 = sr[8*(4*c+3) +: 8];
      mc[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return (last ? sr : mc) ^ rk;
  endfunction

  function automatic logic [127:0] key_step(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w3, rot, t, n0, n1, n2, n3;
    w3  = k[127:96];
    rot = {w3[7:0], w3[31:8]};
    for (int i = 0; i < 4; i++)
      t[8*i +: 8] = sbox(rot[8*i +: 8]);
    t  = t ^ {24'h0, rc};
    n0 = k[31:0]  ^ t;
    n1 = k[63:32] ^ n0;
    n2 = k[95:64] ^ n1;
    n3 = w3       ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  logic [1:0]   st;
  logic [127:0] state_reg, key_reg;
  logic [7:0]   rcon_reg;
  logic [3:0]   rnd;

  logic [127:0] s_nx, k_nx;
  logic [7:0]   r_nx;
  logic [3:0]   rnd_nx;
  logic         accept;

  assign bus.in_ready  = (st == S_IDLE) |
                         ((st == S_DONE) & bus.out_ready);
  assign bus.out_valid = (st == S_DONE);
  assign bus.ct_out    = (st == S_DONE) ? state_reg : '0;
`ifdef AES_KEY_OUT_EN
  assign bus.key_out   = (st == S_DONE) ? key_reg : '0;
`endif

  assign accept = bus.in_valid & bus.in_ready;
  assign rnd_nx = rnd + 4'(UNROLL);

  // chain of UNROLL rounds, key schedule computed alongside
  always_comb begin
    logic [3:0] idx;
    s_nx = state_reg;
    k_nx = key_reg;
    r_nx = rcon_reg;
    idx  = rnd;
    for (int u = 0; u < UNROLL; u++) begin
      idx  = rnd + 4'(u + 1);
      k_nx = key_step(k_nx, r_nx);
      s_nx = round_f(s_nx, k_nx, idx == 4'd10);
      r_nx = xtime(r_nx);
    end
  end

  // control FSM plus datapath registers; loads only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rcon_reg  <= '0;
      rnd       <= '0;
    end else if (accept) begin
      st        <= S_BUSY;
      state_reg <= bus.pt_in ^ bus.key_in;
      key_reg   <= bus.key_in;
      rcon_reg  <= 8'h01;
      rnd       <= '0;
    end else begin
      unique case (st)
        S_IDLE: ;
        S_BUSY: begin
          state_reg <= s_nx;
          key_reg   <= k_nx;
          rcon_reg  <= r_nx;
          rnd       <= rnd_nx;
          if (rnd_nx == RLAST) st <= S_DONE;
        end
        S_DONE: if (bus.out_ready) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
